// File: rtl/octo_engine.sv
// Octopus diver game engine: frame timing, tentacle animation, diver movement,
// scoring with progressive speed-up, deaths and the game-state machine.
module octo_engine #(
  parameter int NPOS         = 5,
  parameter int TMAX         = 4,
  parameter int TPERF        = 6250000,
  parameter int TDEC         = 250000,
  parameter int TMIN         = 2500000,
  parameter int SPEED_STEP   = 10,
  parameter int MAXLIVES     = 3,
  parameter int DEATH_FRAMES = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  input  logic                Up,
  input  logic                Down,
  input  logic                Esc,
  input  logic                Enter,
  output logic [2:0]          Position,
  output logic                Treas,
  output logic [3*NPOS-1:0]   Tent,
  output logic                Corpse,
  output logic [2:0]          State,
  output logic [9:0]          Score,
  output logic [1:0]          Lives,
  output logic                Quit
);

  localparam int TW = $clog2(TPERF + 1);
  localparam int FW = $clog2(2 * NPOS);
  localparam int DW = $clog2(DEATH_FRAMES + 1);

  localparam logic [TW-1:0] PER_INIT   = TW'(TPERF);
  localparam logic [TW-1:0] PER_DEC    = TW'(TDEC);
  localparam logic [TW-1:0] PER_MIN    = TW'(TMIN);
  localparam logic [2:0]    POS_MAX    = 3'(NPOS);
  localparam logic [2:0]    TENT_MAX   = 3'(TMAX);
  localparam logic [9:0]    SCORE_MAX  = 10'd999;
  localparam logic [9:0]    STEP       = 10'(SPEED_STEP);
  localparam logic [1:0]    LIVES_MAX  = 2'(MAXLIVES);
  localparam logic [DW-1:0] DIE_LAST   = DW'(DEATH_FRAMES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(2 * NPOS - 1);

  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, PAUSE = 3'd2, DYING = 3'd3, OVER = 3'd4} state_t;
  typedef enum logic [1:0] {MV_NONE = 2'd0, MV_UP = 2'd1, MV_DOWN = 2'd2} move_t;

  state_t             st, stNext, stFrame;
  move_t              req, reqNext;
  logic [TW-1:0]      tick, tickNext, period, periodNext;
  logic [FW-1:0]      frame, frameNext;
  logic [DW-1:0]      dieCnt, dieNext;
  logic [2:0]         pos, posNext, lane;
  logic               treas, treasNext, quit, quitNext;
  logic [3*NPOS-1:0]  tent, tentNext;
  logic [NPOS-1:0]    ext, extNext;
  logic [9:0]         score, scoreNext;
  logic [1:0]         lives, livesNext;
  logic               running, frameEv, caught;

  function automatic logic [9:0] satInc(input logic [9:0] v);
    return (v == SCORE_MAX) ? v : v + 10'd1;
  endfunction

  function automatic logic [TW-1:0] speedUp(input logic [TW-1:0] p);
    return (p >= PER_MIN + PER_DEC) ? p - PER_DEC : PER_MIN;
  endfunction

  always_comb begin
    stNext = st;  reqNext = req;  tickNext = tick;  periodNext = period;
    frameNext = frame;  dieNext = dieCnt;  posNext = pos;  treasNext = treas;
    quitNext = quit;  tentNext = tent;  extNext = ext;  scoreNext = score;
    livesNext = lives;  lane = '0;  caught = 1'b0;  stFrame = st;
    running = (st == PLAY) || (st == DYING);
    frameEv = running && (tick == period - TW'(1));
    if (running) tickNext = frameEv ? '0 : tick + TW'(1);

    // frame processing completes before any button acts on the state
    if (frameEv) begin
      frameNext = (frame == FRAME_LAST) ? '0 : frame + FW'(1);
      if (st == PLAY) begin
        reqNext = MV_NONE;
        if (req == MV_UP && pos != 3'd0) posNext = pos - 3'd1;
        else if (req == MV_DOWN && pos != POS_MAX) posNext = pos + 3'd1;
        if (posNext == POS_MAX) treasNext = 1'b1;
        else if (posNext == 3'd0 && treas) begin
          treasNext = 1'b0;
          scoreNext = satInc(score);
          if (scoreNext != score && (scoreNext % STEP) == 10'd0) periodNext = speedUp(period);
        end
        for (int k = 0; k < NPOS; k++) begin
          if (frameNext == FW'(2 * k)) begin
            lane = tent[3*k +: 3];
            if (ext[k]) begin
              tentNext[3*k +: 3] = lane + 3'd1;
              if (lane + 3'd1 == TENT_MAX) extNext[k] = 1'b0;
            end else begin
              tentNext[3*k +: 3] = lane - 3'd1;
              if (lane == 3'd1) extNext[k] = 1'b1;
            end
          end
          if (posNext == 3'(k + 1) && tentNext[3*k +: 3] == TENT_MAX) caught = 1'b1;
        end
        if (caught) begin
          posNext = 3'd0;
          treasNext = 1'b0;
          if (lives != LIVES_MAX) livesNext = lives + 2'd1;
          stFrame = DYING;
        end
      end else begin
        // tentacles stay frozen while the corpse is shown
        dieNext = dieCnt + DW'(1);
        if (dieNext == DIE_LAST) begin
          dieNext = '0;
          stFrame = (lives == LIVES_MAX) ? OVER : PAUSE;
        end
      end
    end

    stNext = stFrame;
    case (stFrame)
      IDLE, PAUSE: begin
        if (Esc) quitNext = 1'b1;
        else if (Enter) stNext = PLAY;
      end
      PLAY: begin
        if (Up ^ Down) reqNext = Up ? MV_UP : MV_DOWN;
        if (Esc) stNext = PAUSE;
      end
      OVER: if (Esc || Enter) quitNext = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset || !Enable) begin
      st <= IDLE;  req <= MV_NONE;  tick <= '0;  period <= PER_INIT;
      frame <= FW'(1);  dieCnt <= '0;  pos <= 3'd0;  treas <= 1'b0;
      quit <= 1'b0;  tent <= '0;  ext <= '1;  score <= 10'd0;  lives <= 2'd0;
    end else begin
      st <= stNext;  req <= reqNext;  tick <= tickNext;  period <= periodNext;
      frame <= frameNext;  dieCnt <= dieNext;  pos <= posNext;  treas <= treasNext;
      quit <= quitNext;  tent <= tentNext;  ext <= extNext;  score <= scoreNext;
      lives <= livesNext;
    end
  end

  assign Position = pos;
  assign Treas    = treas;
  assign Tent     = tent;
  assign Corpse   = (st == DYING);
  assign State    = st;
  assign Score    = score;
  assign Lives    = lives;
  assign Quit     = quit;

endmodule
